// File: rtl/opl3_slot_reader_pkg.sv
// rtl/opl3_slot_reader_pkg.sv - shared types for the slot parameter read sequencer
package opl3_slot_reader_pkg;

    localparam int NUM_SLOTS_DEFAULT = 36;
    localparam int SLOT_W_DEFAULT    = $clog2(NUM_SLOTS_DEFAULT);

    typedef logic [SLOT_W_DEFAULT-1:0] slot_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    typedef struct packed {
        logic      valid;
        slot_idx_t slot;
    } inflight_t;

endpackage

// File: rtl/slot_reader_fifo.sv
// rtl/slot_reader_fifo.sv - synchronous FIFO holding {slot, data} read results
module slot_reader_fifo #(
    parameter int WIDTH = 38,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/opl3_slot_param_reader.sv
// rtl/opl3_slot_param_reader.sv - per-sample sweep of the slot RAM onto a valid/ready stream (option: OPL3_SLOT_READER_STATS_EN)
module opl3_slot_param_reader
    import opl3_slot_reader_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_SLOTS    = NUM_SLOTS_DEFAULT,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         sample_clk_en,
    output logic                         mem_reb,
    output logic [$clog2(NUM_SLOTS)-1:0] mem_addrb,
    input  logic [DATA_WIDTH-1:0]        mem_dob,
    output logic                         slot_valid,
    input  logic                         slot_ready,
    output logic [DATA_WIDTH-1:0]        slot_data,
    output logic [$clog2(NUM_SLOTS)-1:0] slot_num,
    output logic                         busy,
    output logic                         overrun
`ifdef OPL3_SLOT_READER_STATS_EN
    ,
    output logic [15:0]                  overrun_count,
    output logic [15:0]                  stall_cycles
`endif
);

    localparam int SLOT_W = $clog2(NUM_SLOTS);
    localparam int CW     = $clog2(FIFO_DEPTH + 1);
    localparam int FW     = SLOT_W + DATA_WIDTH;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

    state_t            state;
    state_t            state_nxt;
    logic [SLOT_W-1:0] addr;
    logic              issue;
    logic              start;
    logic              drain_done;
    logic              pop;
    logic              cap_valid;
    logic [SLOT_W-1:0] cap_slot;
    logic [2:0]        inflight_cnt;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [FW-1:0]     fifo_head;

    assign start = (state == IDLE) && sample_clk_en;
    assign pop   = !fifo_empty && slot_ready;

    // Reads are only issued when a FIFO slot is reserved for them; the current pop
    // is deliberately ignored so slot_ready never reaches mem_reb combinationally.
    always_comb begin
        state_nxt  = state;
        issue      = 1'b0;
        drain_done = 1'b0;
        if ((state == RUN) && !fifo_full &&
            ((int'(fifo_count) + int'(inflight_cnt)) < FIFO_DEPTH)) begin
            issue = 1'b1;
        end
        if ((inflight_cnt == '0) &&
            ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop))) begin
            drain_done = 1'b1;
        end
        case (state)
            IDLE:    if (sample_clk_en) state_nxt = RUN;
            RUN:     if (issue && (addr == LAST_SLOT)) state_nxt = DRAIN;
            DRAIN:   if (drain_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Sweep state, read address and overrun pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            addr    <= '0;
            overrun <= 1'b0;
        end else begin
            state   <= state_nxt;
            overrun <= sample_clk_en && (state != IDLE);
            if (start) begin
                addr <= '0;
            end else if (issue && (addr != LAST_SLOT)) begin
                addr <= addr + 1'b1;
            end
        end
    end

    generate
        if (READ_LATENCY == 0) begin : g_lat0
            assign cap_valid    = issue;
            assign cap_slot     = addr;
            assign inflight_cnt = '0;
        end else begin : g_pipe
            logic [READ_LATENCY-1:0]             pv;
            logic [READ_LATENCY-1:0][SLOT_W-1:0] ps;

            // Follows each read through the RAM latency so data is tagged on arrival.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    pv <= '0;
                    ps <= '0;
                end else begin
                    pv[0] <= issue;
                    ps[0] <= addr;
                    for (int i = 1; i < READ_LATENCY; i++) begin
                        pv[i] <= pv[i-1];
                        ps[i] <= ps[i-1];
                    end
                end
            end

            assign cap_valid    = pv[READ_LATENCY-1];
            assign cap_slot     = ps[READ_LATENCY-1];
            assign inflight_cnt = 3'($countones(pv));
        end
    endgenerate

    slot_reader_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (cap_valid),
        .push_data ({cap_slot, mem_dob}),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign mem_reb    = issue;
    assign mem_addrb  = addr;
    assign busy       = (state != IDLE);
    assign slot_valid = !fifo_empty;
    assign slot_num   = fifo_empty ? '0 : fifo_head[FW-1:DATA_WIDTH];
    assign slot_data  = fifo_empty ? '0 : fifo_head[DATA_WIDTH-1:0];

`ifdef OPL3_SLOT_READER_STATS_EN
    // Saturating diagnostics: overruns since reset, stalled cycles since sweep start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun_count <= '0;
            stall_cycles  <= '0;
        end else begin
            if (overrun && (overrun_count != 16'hFFFF)) begin
                overrun_count <= overrun_count + 1'b1;
            end
            if (start) begin
                stall_cycles <= '0;
            end else if (slot_valid && !slot_ready && (stall_cycles != 16'hFFFF)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/opl3_slot_param_reader.md
Name: opl3_slot_param_reader

Overview:
- Read-side sequencer for the per-slot parameter RAM (simple dual-port, host writes port A).
- Once per sample period it walks slot addresses 0..NUM_SLOTS-1 on read port B.
- It tracks the RAM's fixed read latency and delivers {slot_num, slot_data} to the operator pipeline over a valid/ready stream.
- A small FIFO absorbs downstream backpressure so no read result is ever lost.

Parameters:
- DATA_WIDTH, 32: width of one slot parameter word.
- NUM_SLOTS, 36: slots read per sample period.
- READ_LATENCY, 1: RAM read latency in cycles, 0, 1 or 2; must equal the RAM's OUTPUT_DELAY.
- FIFO_DEPTH, 4: output buffer entries; legal range READ_LATENCY+2 to 8.

Ports:
- clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- sample_clk_en  in  1  one-cycle pulse; starts a sweep.
- mem_reb  out  1  RAM read enable (port B).
- mem_addrb  out  $clog2(NUM_SLOTS)  RAM read address.
- mem_dob  in  DATA_WIDTH  RAM read data.
- slot_valid  out  1  output word available.
- slot_ready  in  1  downstream accepts.
- slot_data  out  DATA_WIDTH  parameter word.
- slot_num  out  $clog2(NUM_SLOTS)  slot index of slot_data.
- busy  out  1  sweep in progress.
- overrun  out  1  one-cycle pulse: sample_clk_en arrived while busy.

Behaviour:
- Clock and reset: single clock domain on clk. reset_n is asynchronous assert, synchronous deassert at the system level.
- Reset values: all outputs 0. FSM=IDLE, address counter 0, in-flight pipe cleared, FIFO empty.
- Reset mid-sweep: in-flight reads and FIFO contents are discarded. The next sweep starts at slot 0.
- FSM states:
  - IDLE: on sample_clk_en go to RUN with issue address 0.
  - RUN: issue reads (see next bullet). After issuing address NUM_SLOTS-1, go to DRAIN.
  - DRAIN: return to IDLE when the in-flight pipe is empty, the FIFO is empty and no handshake is pending.
- Read issue: mem_reb=1 with mem_addrb=addr only when (fifo_count + inflight_count) < FIFO_DEPTH. The current-cycle pop is not counted, so there is no combinational path from slot_ready to mem_reb. addr increments on each issue. mem_reb=0 otherwise, and mem_addrb holds its value.
- In-flight tracking: a READ_LATENCY-deep shift register carries {valid, slot index}. A read issued in cycle t is captured from mem_dob at the end of cycle t+READ_LATENCY. For READ_LATENCY=0 the capture is in the same cycle as the issue.
- Output stream:
  - FIFO head drives slot_valid, slot_data and slot_num.
  - Handshake occurs when slot_valid && slot_ready.
  - While slot_valid=1 and not accepted, slot_data and slot_num are held stable.
  - Simultaneous push and pop are allowed, including when the FIFO is full or empty.
- Latency: with slot_ready held at 1, sample_clk_en in cycle 0 gives the first slot_valid in cycle 2+READ_LATENCY. Output then sustains one word per cycle, and the last word (slot NUM_SLOTS-1) appears in cycle 1+READ_LATENCY+NUM_SLOTS.
- busy = (state != IDLE). It falls the cycle after the final handshake.
- sample_clk_en while busy: the pulse is ignored (no restart) and overrun pulses 1 cycle later.
- Order: slots are always delivered in ascending order 0..NUM_SLOTS-1, with no duplicates and no drops under any slot_ready pattern.
- Counters: the address counter does not wrap past NUM_SLOTS-1 within a sweep; the next sweep reloads it to 0.

Optional Feature:
- OPL3_SLOT_READER_STATS_EN defined: adds output overrun_count[15:0].
  - Increments on each overrun pulse and saturates at 16'hFFFF.
  - Cleared by reset_n only.
  - Also adds output stall_cycles[15:0], a saturating count of cycles with slot_valid && !slot_ready, cleared at each sweep start.
- Undefined: neither port nor counter exists. All other behaviour is identical.

Decomposition:
- Package opl3_slot_reader_pkg:
  - NUM_SLOTS_DEFAULT=36.
  - Typedef for the slot index.
  - Enum state_t {IDLE, RUN, DRAIN}.
  - Typedef for the in-flight struct {valid, slot}.
- Sub-module slot_reader_fifo: synchronous FIFO with params WIDTH and DEPTH, ports push/pop/full/empty/count, reset clk/reset_n. Holds {slot, data}.

Test Plan:
- READ_LATENCY=1, RAM preloaded data=slot*16'h0101, slot_ready=1; pulse sample_clk_en at cycle 0 -> slot_valid rises cycle 3, 36 consecutive words slot 0..35 with matching data, busy falls cycle 39.
- READ_LATENCY 0 and 2, same stimulus -> first valid at cycle 2 and cycle 4 respectively; data and order identical.
- slot_ready random 30% duty -> all 36 words in order, mem_reb never issues with fifo_count+inflight>=4, no word lost or repeated, held data stable while stalled.
- sample_clk_en re-pulsed at cycle 10 of a sweep -> overrun=1 at cycle 11 only, sweep continues unchanged; with OPL3_SLOT_READER_STATS_EN, overrun_count=1.
- reset_n low at cycle 15 for 2 cycles -> all outputs 0 immediately; next sample_clk_en yields a full clean sweep starting at slot 0.
- slot_ready=0 for 20 cycles after start -> FIFO fills to 4, mem_reb stays 0; release -> slots 0..35 delivered in order.
